// File: rtl/pcileech_pcie_cfg_arb_pkg.sv
// pcileech_pcie_cfg_pkg: shared state encodings and constants for the PCIe config-port handling modules
package pcileech_pcie_cfg_pkg;

    typedef enum logic [1:0] {
        S_ARB_IDLE,
        S_ARB_WAIT,
        S_ARB_GAP
    } arb_state_e;

    localparam logic [31:0] CFG_RSP_TIMEOUT_DATA = 32'hFFFFFFFF;

endpackage

// File: rtl/pcileech_pcie_cfg_arb_rr_pick.sv
// pcileech_rr_pick: combinational round-robin picker
//   req_i  : request vector
//   last_i : index of the previous grant; search starts at last_i+1 (mod N)
//   gnt_o  : one-hot grant (all zero when nothing requests)
//   idx_o  : index of the granted requester
//   any_o  : at least one request present
module pcileech_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    always_comb begin
        idx_o = '0;
        // Walk from the farthest candidate to the nearest so the nearest requester after last_i wins.
        for (int i = N; i >= 1; i--)
            if (req_i[(int'(last_i) + i) % N])
                idx_o = $clog2(N)'((int'(last_i) + i) % N);
        any_o = |req_i;
        gnt_o = any_o ? N'(1) << idx_o : '0;
    end

endmodule

// File: rtl/pcileech_pcie_cfg_arb.sv
// pcileech_pcie_cfg_arb: shares the PCIe core config-management port between N_REQ requesters
//   req_*   : per-requester request fields, held until the one-hot req_ack pulse
//   rsp_*   : response (rsp_err=1 means timed out), valid with req_ack
//   busy    : arbiter not idle; stat_timeouts: saturating timeout count
//   cfg_*   : core request fields/strobes and core response (cfg_do, cfg_rd_wr_done)
module pcileech_pcie_cfg_arb
    import pcileech_pcie_cfg_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk_pcie,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_wr,
    input  logic [10*N_REQ-1:0]   req_dwaddr,
    input  logic [32*N_REQ-1:0]   req_di,
    input  logic [4*N_REQ-1:0]    req_be,
    output logic [N_REQ-1:0]      req_ack,
    output logic                  rsp_err,
    output logic [31:0]           rsp_do,
    output logic                  busy,
    output logic [7:0]            stat_timeouts,
    output logic [9:0]            cfg_dwaddr,
    output logic [31:0]           cfg_di,
    output logic [3:0]            cfg_byte_en,
    output logic                  cfg_rd_en,
    output logic                  cfg_wr_en,
    input  logic [31:0]           cfg_do,
    input  logic                  cfg_rd_wr_done
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic             rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [IW-1:0]    last_q, last_d, pick_idx;
    logic [N_REQ-1:0] gnt_q, gnt_d, pick_gnt, ack_q, ack_d;
    logic             pick_any, pick_wr, expire;
    logic             err_q, err_d, busy_q, busy_d;
    logic [31:0]      rsp_q, rsp_d, di_q, di_d;
    logic [9:0]       addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [7:0]       stat_q, stat_d;

    pcileech_rr_pick #(.N(N_REQ)) u_pick (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign pick_wr = req_wr[pick_idx];
    assign expire  = cnt_q == 16'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = err_q;
        rsp_d   = rsp_q;
        addr_d  = addr_q;
        di_d    = di_q;
        be_d    = be_q;
        stat_d  = stat_q;
        case (state_q)
            S_ARB_IDLE: if (pick_any) begin
                state_d = S_ARB_WAIT;
                rd_en_d = ~pick_wr;
                wr_en_d = pick_wr;
                addr_d  = req_dwaddr[10*int'(pick_idx) +: 10];
                di_d    = pick_wr ? req_di[32*int'(pick_idx) +: 32] : '0;
                be_d    = pick_wr ? req_be[4*int'(pick_idx) +: 4] : '0;
                cnt_d   = '0;
                last_d  = pick_idx;
                gnt_d   = pick_gnt;
            end
            // Done takes priority over a timeout expiring in the same cycle.
            S_ARB_WAIT: if (cfg_rd_wr_done || expire) begin
                state_d = S_ARB_GAP;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                ack_d   = gnt_q;
                err_d   = ~cfg_rd_wr_done;
                rsp_d   = cfg_rd_wr_done ? (rd_en_q ? cfg_do : '0) : CFG_RSP_TIMEOUT_DATA;
                stat_d  = (!cfg_rd_wr_done && stat_q != 8'hFF) ? stat_q + 8'd1 : stat_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            default: state_d = S_ARB_IDLE;
        endcase
        busy_d = state_d != S_ARB_IDLE;
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ARB_IDLE;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
            addr_q  <= '0;
            di_q    <= '0;
            be_q    <= '0;
            stat_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            be_q    <= be_d;
            stat_q  <= stat_d;
            busy_q  <= busy_d;
        end
    end

    // Strobes drop combinationally in the done cycle so the core never sees a second request.
    assign cfg_rd_en     = rd_en_q & ~cfg_rd_wr_done;
    assign cfg_wr_en     = wr_en_q & ~cfg_rd_wr_done;
    assign req_ack       = ack_q;
    assign rsp_err       = err_q;
    assign rsp_do        = rsp_q;
    assign busy          = busy_q;
    assign stat_timeouts = stat_q;
    assign cfg_dwaddr    = addr_q;
    assign cfg_di        = di_q;
    assign cfg_byte_en   = be_q;

endmodule

// File: tb/tb_pcileech_pcie_cfg_arb.sv
// tb_pcileech_pcie_cfg_arb: scoreboard bench for the config-port arbiter (N_REQ=2, TIMEOUT_CYCLES=8)
module tb_pcileech_pcie_cfg_arb;

    localparam int T = 8;

    typedef struct {
        int          r;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] di;
        logic [3:0]  be;
        logic        err;
        logic [31:0] data;
        int          scyc;
        int          alat;
    } acc_t;

    logic        clk_pcie = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0, req_wr = '0;
    logic [19:0] req_dwaddr = '0;
    logic [63:0] req_di = '0;
    logic [7:0]  req_be = '0;
    logic [1:0]  req_ack;
    logic        rsp_err, busy, cfg_rd_en, cfg_wr_en;
    logic [31:0] rsp_do, cfg_di;
    logic [7:0]  stat_timeouts;
    logic [9:0]  cfg_dwaddr;
    logic [3:0]  cfg_byte_en;
    logic [31:0] cfg_do = '0;
    logic        cfg_rd_wr_done = 1'b0;

    pcileech_pcie_cfg_arb #(.N_REQ(2), .TIMEOUT_CYCLES(T)) dut (
        .clk_pcie       (clk_pcie),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_dwaddr     (req_dwaddr),
        .req_di         (req_di),
        .req_be         (req_be),
        .req_ack        (req_ack),
        .rsp_err        (rsp_err),
        .rsp_do         (rsp_do),
        .busy           (busy),
        .stat_timeouts  (stat_timeouts),
        .cfg_dwaddr     (cfg_dwaddr),
        .cfg_di         (cfg_di),
        .cfg_byte_en    (cfg_byte_en),
        .cfg_rd_en      (cfg_rd_en),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_do         (cfg_do),
        .cfg_rd_wr_done (cfg_rd_wr_done)
    );

    always #5 clk_pcie = ~clk_pcie;

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, wcnt = 0, n_rd = 0, n_wr = 0;
    int   core_lat = 2;
    logic [31:0] core_data = '0;
    logic extra_done = 1'b0;
    logic [1:0] acked = '0;
    int   t_load [2];
    acc_t rq [2][$];
    acc_t sb [$];
    int   ord [$];
    acc_t d_drv, e_mon;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Queue a request for requester r; the expected response follows from the current core behaviour.
    task automatic req(input int r, input logic wr, input logic [9:0] a, input logic [31:0] di,
                       input logic [3:0] be, input int alat);
        acc_t x;
        x.r = r; x.wr = wr; x.addr = a; x.di = di; x.be = be; x.alat = alat;
        x.err  = core_lat == 0;
        x.data = x.err ? 32'hFFFFFFFF : (wr ? 32'h0 : core_data);
        x.scyc = x.err ? T : core_lat - 1;
        rq[r].push_back(x);
        sb.push_back(x);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk_pcie);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk_pcie);
    endtask

    always @(posedge clk_pcie) cyc++;

    // Requesters: drop or replace the request in the cycle after its ack.
    always @(posedge clk_pcie) begin
        #1;
        for (int r = 0; r < 2; r++) begin
            if (acked[r]) begin
                req_valid[r] = 1'b0;
                acked[r] = 1'b0;
            end
            if (!req_valid[r] && rq[r].size() != 0) begin
                d_drv = rq[r].pop_front();
                req_wr[r] = d_drv.wr;
                req_dwaddr[r*10 +: 10] = d_drv.addr;
                req_di[r*32 +: 32] = d_drv.di;
                req_be[r*4 +: 4] = d_drv.be;
                req_valid[r] = 1'b1;
                t_load[r] = cyc;
            end
        end
    end

    // Core model: completes after core_lat strobe cycles (0 = never completes).
    always @(posedge clk_pcie) begin
        #1;
        cfg_rd_wr_done = extra_done;
        cfg_do = $urandom;
        #1;
        if (cfg_rd_en | cfg_wr_en) begin
            wcnt++;
            if (core_lat != 0 && wcnt == core_lat) begin
                cfg_rd_wr_done = 1'b1;
                cfg_do = core_data;
                wcnt = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk_pcie) if (rst_n) begin
        if (cfg_rd_en) n_rd++;
        if (cfg_wr_en) n_wr++;
        if (req_ack != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", req_ack, 0);
            end else begin
                e_mon = sb.pop_front();
                chk("ack_vec", req_ack, 32'(1) << e_mon.r);
                chk("rsp_err", rsp_err, e_mon.err);
                chk("rsp_do", rsp_do, e_mon.data);
                chk("cfg_dwaddr", cfg_dwaddr, e_mon.addr);
                chk("cfg_di", cfg_di, e_mon.wr ? e_mon.di : 32'h0);
                chk("cfg_byte_en", cfg_byte_en, e_mon.wr ? e_mon.be : 4'h0);
                chk("rd_strobe_cycles", n_rd, e_mon.wr ? 0 : e_mon.scyc);
                chk("wr_strobe_cycles", n_wr, e_mon.wr ? e_mon.scyc : 0);
                chk("gap_strobes", {cfg_rd_en, cfg_wr_en}, 2'b00);
                chk("gap_busy", busy, 1'b1);
                if (e_mon.alat != 0) chk("ack_latency", cyc - t_load[e_mon.r], e_mon.alat);
                if (ord.size() != 0) chk("grant_order", e_mon.r, ord.pop_front());
            end
            acked = acked | req_ack;
            n_rd = 0;
            n_wr = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_pcie);
        chk("rst_ack", req_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {cfg_rd_en, cfg_wr_en}, 0);
        chk("rst_fields", {cfg_dwaddr, cfg_di, cfg_byte_en}, 0);
        chk("rst_rsp", {rsp_err, rsp_do}, 0);
        chk("rst_stat", stat_timeouts, 0);
        @(posedge clk_pcie);
        #3 rst_n = 1'b1;
        @(negedge clk_pcie);

        core_lat = 3; core_data = 32'h10EE7021;
        req(0, 1'b0, 10'h004, 32'h0, 4'h0, 4);
        drain(50);
        chk("busy_after_read", busy, 0);

        core_lat = 2; core_data = 32'h55AA1234;
        req(1, 1'b1, 10'h001, 32'h00000406, 4'b0011, 3);
        drain(50);
        req(1, 1'b0, 10'h2A5, 32'hDEADBEEF, 4'hF, 3);
        drain(50);

        extra_done = 1'b1;
        repeat (3) begin
            @(negedge clk_pcie);
            chk("spur_done_busy", busy, 0);
            chk("spur_done_ack", req_ack, 0);
        end
        extra_done = 1'b0;
        repeat (2) @(negedge clk_pcie);
        chk("spur_done_stat", stat_timeouts, 0);

        core_lat = 2; core_data = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            req(0, 1'b0, 10'(16 + i), 32'h0, 4'h0, 0);
            req(1, 1'b1, 10'(32 + i), 32'(32'h1000 + i), 4'(i + 1), 0);
            ord.push_back(0);
            ord.push_back(1);
        end
        drain(100);

        core_lat = 0;
        req(0, 1'b0, 10'h0FF, 32'h0, 4'h0, T + 1);
        drain(50);
        chk("stat_one", stat_timeouts, 1);

        core_lat = T; core_data = 32'h0BADF00D;
        req(0, 1'b0, 10'h100, 32'h0, 4'h0, T + 1);
        drain(50);
        chk("stat_done_wins", stat_timeouts, 1);

        core_lat = 0;
        for (int i = 0; i < 299; i++) req(0, i[0], 10'(i), 32'(i), 4'(i), T + 1);
        drain(5000);
        chk("stat_saturated", stat_timeouts, 255);

        rq[0].push_back('{0, 1'b0, 10'h3C3, 32'h0, 4'h0, 1'b0, 32'h0, 0, 0});
        repeat (3) @(posedge clk_pcie);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_rd_en", cfg_rd_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ack", req_ack, 0);
        chk("async_rst_stat", stat_timeouts, 0);
        req_valid = 2'b00;
        @(posedge clk_pcie);
        #3 rst_n = 1'b1;
        n_rd = 0;
        n_wr = 0;
        chk("post_rst_no_ack", req_ack, 0);
        core_lat = 2; core_data = 32'h12345678;
        req(0, 1'b0, 10'h011, 32'h0, 4'h0, 3);
        req(1, 1'b0, 10'h022, 32'h0, 4'h0, 0);
        ord.push_back(0);
        ord.push_back(1);
        drain(50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
